memory_stage: RTL and testbench

Memory-access stage of the vector/scalar processor pipeline, between execute and write-back. Performs scalar or 6-lane vector loads and stores against a 1024 × 24-bit data memory, exposes memory-mapped I/O (switches, GPIO, 16-bit display register), and registers the write-back bundle into a 182-bit output pipeline buffer.

---
 rtl/memory_stage_pkg.sv | 39 +++
 rtl/memory_stage_data_memory.sv | 33 +++
 rtl/memory_stage.sv | 128 ++++++++++++
 tb/tb_memory_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared constants and types for the memory-access stage: op classes, memory geometry,
// the memory-mapped I/O addresses and the layout of the write-back bundle.
package memory_stage_pkg;

    typedef enum logic [1:0] {
        OP_SALU = 2'b00,
        OP_VALU = 2'b01,
        OP_MEM  = 2'b10
    } op_type_e;

    localparam int MEM_DEPTH = 1024;
    localparam int ADDR_W    = 10;
    localparam int LANE_W    = 24;
    localparam int LANES     = 6;
    localparam int VEC_W     = LANE_W * LANES;

    localparam logic [LANE_W-1:0] IO_Q   = 24'hFFFFF0;
    localparam logic [LANE_W-1:0] IO_SW  = 24'hFFFFF1;
    localparam logic [LANE_W-1:0] IO_GPI = 24'hFFFFF2;
    localparam logic [LANE_W-1:0] IO_GPO = 24'hFFFFF3;

    typedef struct packed {
        logic [1:0]        op_type;
        logic [3:0]        op_code;
        logic              mode_sel;
        logic              mem_to_reg;
        logic              reg_write;
        logic              reg_write_v;
        logic [3:0]        rc;
        logic [LANE_W-1:0] address2;
        logic [VEC_W-1:0]  result;
    } wb_bundle_t;

    // Lane i of a vector access sits at base+i; the 10-bit sum wraps at the memory end.
    function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] base, input int lane);
        return base + ADDR_W'(lane);
    endfunction

endpackage

// File: rtl/memory_stage_data_memory.sv
// 1024 x 24-bit data memory with a six-lane combinational read port and a
// six-lane, per-lane-enabled write port on the rising clock edge.
module data_memory
    import memory_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [LANES-1:0]      lane_en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [VEC_W-1:0]      wdata,
    output logic [VEC_W-1:0]      rdata
);

    logic [LANE_W-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_en[i]) begin
                    mem_q[lane_addr(addr, i)] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < LANES; i++) begin
            rdata[i*LANE_W +: LANE_W] = mem_q[lane_addr(addr, i)];
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory-access stage: scalar/vector loads and stores, memory-mapped I/O decode,
// write-back result mux and the falling-edge output buffer.
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            opType,
    input  logic [3:0]            opCode,
    input  logic [VEC_W-1:0]      address1,
    input  logic [LANE_W-1:0]     address2,
    input  logic                  memWrite,
    input  logic                  memToReg,
    input  logic                  regWrite,
    input  logic                  regWriteV,
    input  logic                  modeSel,
    input  logic [3:0]            Rc,
    input  logic [VEC_W-1:0]      writeData,
    input  logic [3:0]            switches,
    input  logic [35:0]           gpio1,
    output logic [35:0]           gpio2,
    output logic [15:0]           q,
    output logic [181:0]          bufferOut
);

    logic [LANE_W-1:0] eff_addr;
    logic              is_vec;
    logic              io_hit;
    logic              is_store;
    logic              mem_we;
    logic [LANES-1:0]  lane_en;
    logic [VEC_W-1:0]  mem_rdata;
    logic [VEC_W-1:0]  read_data;
    logic [VEC_W-1:0]  result;

    logic [15:0]       q_q, q_d;
    logic [35:0]       gpio2_q, gpio2_d;
    wb_bundle_t        buf_q, buf_d;

    logic              unused_gpio_hi;
    assign unused_gpio_hi = ^gpio1[35:24];

    // Only scalar accesses see the I/O map; vector accesses always go to memory.
    // Holding rst low across a rising edge suppresses any store on that edge.
    always_comb begin
        eff_addr = address1[LANE_W-1:0];
        is_vec   = opCode[0];
        io_hit   = !is_vec && (eff_addr inside {IO_Q, IO_SW, IO_GPI, IO_GPO});
        is_store = en && rst && memWrite && (opType == OP_MEM);
        mem_we   = is_store && !io_hit;
        lane_en  = is_vec ? {LANES{1'b1}} : LANES'(1);
    end

    data_memory u_data_memory (
        .clk     (clk),
        .we      (mem_we),
        .lane_en (lane_en),
        .addr    (eff_addr[ADDR_W-1:0]),
        .wdata   (writeData),
        .rdata   (mem_rdata)
    );

    // Write-only I/O registers read back as zero.
    always_comb begin
        read_data = '0;
        if (is_vec) begin
            read_data = mem_rdata;
        end else if (eff_addr == IO_SW) begin
            read_data[LANE_W-1:0] = {20'd0, switches};
        end else if (eff_addr == IO_GPI) begin
            read_data[LANE_W-1:0] = gpio1[LANE_W-1:0];
        end else if (!io_hit) begin
            read_data[LANE_W-1:0] = mem_rdata[LANE_W-1:0];
        end
        result = memToReg ? read_data : address1;
    end

    always_comb begin
        q_d     = q_q;
        gpio2_d = gpio2_q;
        if (is_store && !is_vec && eff_addr == IO_Q) begin
            q_d = writeData[15:0];
        end
        if (is_store && !is_vec && eff_addr == IO_GPO) begin
            gpio2_d = writeData[35:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q     <= '0;
            gpio2_q <= '0;
        end else begin
            q_q     <= q_d;
            gpio2_q <= gpio2_d;
        end
    end

    always_comb begin
        buf_d = buf_q;
        if (en) begin
            buf_d.op_type     = opType;
            buf_d.op_code     = opCode;
            buf_d.mode_sel    = modeSel;
            buf_d.mem_to_reg  = memToReg;
            buf_d.reg_write   = regWrite;
            buf_d.reg_write_v = regWriteV;
            buf_d.rc          = Rc;
            buf_d.address2    = address2;
            buf_d.result      = result;
        end
    end

    // Falling-edge capture lets load data written at the preceding rising edge land here.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign q         = q_q;
    assign gpio2     = gpio2_q;
    assign bufferOut = buf_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus randomized traffic checked
// against an array-based behavioural model of memory, I/O registers and buffer.
module tb_memory_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   opType;
    logic [3:0]   opCode;
    logic [143:0] address1;
    logic [23:0]  address2;
    logic         memWrite, memToReg, regWrite, regWriteV, modeSel;
    logic [3:0]   Rc;
    logic [143:0] writeData;
    logic [3:0]   switches;
    logic [35:0]  gpio1;
    logic [35:0]  gpio2;
    logic [15:0]  q;
    logic [181:0] bufferOut;

    memory_stage dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .opType    (opType),
        .opCode    (opCode),
        .address1  (address1),
        .address2  (address2),
        .memWrite  (memWrite),
        .memToReg  (memToReg),
        .regWrite  (regWrite),
        .regWriteV (regWriteV),
        .modeSel   (modeSel),
        .Rc        (Rc),
        .writeData (writeData),
        .switches  (switches),
        .gpio1     (gpio1),
        .gpio2     (gpio2),
        .q         (q),
        .bufferOut (bufferOut)
    );

    always #5 clk = ~clk;

    logic [23:0]  ref_mem [1024];
    logic [15:0]  ref_q;
    logic [35:0]  ref_gpio2;
    logic [181:0] ref_buf;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic check(input string tag, input logic [181:0] got, input logic [181:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [143:0] ref_read();
        logic [143:0] r;
        logic [23:0]  a;
        r = '0;
        a = address1[23:0];
        if (opCode[0]) begin
            for (int i = 0; i < 6; i++) r[i*24 +: 24] = ref_mem[(int'(a[9:0]) + i) % 1024];
        end else begin
            case (a)
                24'hFFFFF1:             r[23:0] = {20'd0, switches};
                24'hFFFFF2:             r[23:0] = gpio1[23:0];
                24'hFFFFF0, 24'hFFFFF3: r[23:0] = 24'd0;
                default:                r[23:0] = ref_mem[int'(a[9:0])];
            endcase
        end
        return r;
    endfunction

    // One transaction: update the model, let the DUT see a rising then falling edge, compare.
    task automatic step(input string tag);
        logic [23:0]  a;
        logic [143:0] rd;
        a = address1[23:0];
        if (en) begin
            if (memWrite && opType == 2'b10) begin
                if (opCode[0]) begin
                    for (int i = 0; i < 6; i++) ref_mem[(int'(a[9:0]) + i) % 1024] = writeData[i*24 +: 24];
                end else if (a == 24'hFFFFF0) begin
                    ref_q = writeData[15:0];
                end else if (a == 24'hFFFFF3) begin
                    ref_gpio2 = writeData[35:0];
                end else if (a != 24'hFFFFF1 && a != 24'hFFFFF2) begin
                    ref_mem[int'(a[9:0])] = writeData[23:0];
                end
            end
            rd = ref_read();
            ref_buf = {opType, opCode, modeSel, memToReg, regWrite, regWriteV, Rc, address2,
                       memToReg ? rd : address1};
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        check({tag, "/buf"}, bufferOut, ref_buf);
        check({tag, "/q"}, 182'(q), 182'(ref_q));
        check({tag, "/gpio2"}, 182'(gpio2), 182'(ref_gpio2));
    endtask

    task automatic idle();
        en = 1'b1; opType = 2'b00; opCode = 4'd0; memWrite = 1'b0; memToReg = 1'b0;
        regWrite = 1'b0; regWriteV = 1'b0; modeSel = 1'b0; Rc = 4'd0;
        address1 = '0; address2 = '0; writeData = '0;
    endtask

    logic [127:0] rnd;
    logic [23:0]  ra;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        ref_q = '0; ref_gpio2 = '0; ref_buf = '0;
        switches = 4'b0000; gpio1 = '0;
        idle();
        opType = 2'b10; memWrite = 1'b1; address1 = {$urandom, $urandom, $urandom, $urandom, 16'h1234};
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("reset/buf", bufferOut, '0);
        check("reset/q", 182'(q), '0);
        check("reset/gpio2", 182'(gpio2), '0);
        @(negedge clk);
        #1 rst = 1'b1;

        // Bring memory to a known all-zero state.
        for (int b = 0; b < 1024; b += 6) begin
            idle(); opType = 2'b10; opCode = 4'd1; memWrite = 1'b1; address1 = 144'(b);
            step("clear");
        end

        idle(); opType = 2'b10; opCode = 4'd9; memWrite = 1'b1; address1 = 144'd500; writeData = 144'd35;
        step("vst500");
        memWrite = 1'b0; memToReg = 1'b1;
        step("vld500");
        check("vld500/lane0", 182'(bufferOut[23:0]), 182'd35);
        check("vld500/lanes1_5", 182'(bufferOut[143:24]), '0);

        idle(); opType = 2'b01; opCode = 4'd4; address1 = 144'd700; Rc = 4'd12; regWrite = 1'b1;
        step("pass");
        check("pass/result", 182'(bufferOut[143:0]), 182'd700);
        check("pass/rc", 182'(bufferOut[171:168]), 182'd12);
        check("pass/regwrite", 182'(bufferOut[173]), 182'd1);
        idle(); opType = 2'b10; opCode = 4'd1; memToReg = 1'b1; address1 = 144'd700;
        step("ld700");
        check("ld700/lane0", 182'(bufferOut[23:0]), '0);

        idle(); opType = 2'b10; memWrite = 1'b1; address1 = 144'hFFFFF0; writeData = 144'hABCD;
        step("io_q");
        check("io_q/value", 182'(q), 182'hABCD);
        idle(); opType = 2'b10; memToReg = 1'b1; address1 = 144'hFFFFF1; switches = 4'b1101;
        step("io_sw");
        check("io_sw/lane0", 182'(bufferOut[23:0]), 182'd13);
        idle(); opType = 2'b10; memWrite = 1'b1; address1 = 144'hFFFFF3; writeData = 144'h5;
        step("io_gpo");
        check("io_gpo/value", 182'(gpio2), 182'd5);
        idle(); opType = 2'b10; memToReg = 1'b1; address1 = 144'hFFFFF2; gpio1 = 36'hF_00A5_5A3C;
        step("io_gpi");
        check("io_gpi/lane0", 182'(bufferOut[23:0]), 182'h A55A3C);

        idle(); en = 1'b0; opType = 2'b10; opCode = 4'd1; memWrite = 1'b1; address1 = 144'd500;
        writeData = 144'd99; memToReg = 1'b1;
        step("stall");
        idle(); opType = 2'b10; opCode = 4'd1; memToReg = 1'b1; address1 = 144'd500;
        step("after_stall");
        check("after_stall/lane0", 182'(bufferOut[23:0]), 182'd35);

        idle(); opType = 2'b10; opCode = 4'd1; memWrite = 1'b1; address1 = 144'd1022;
        for (int i = 0; i < 6; i++) writeData[i*24 +: 24] = 24'(i + 1);
        step("wrap_st");
        idle(); opType = 2'b10; memToReg = 1'b1; address1 = 144'd0;
        step("wrap_ld0");
        check("wrap/mem0", 182'(bufferOut[23:0]), 182'd3);
        address1 = 144'd3;
        step("wrap_ld3");
        check("wrap/mem3", 182'(bufferOut[23:0]), 182'd6);

        // Reset mid-operation: outputs clear at once and the store under reset is dropped.
        idle(); opType = 2'b10; opCode = 4'd1; memWrite = 1'b1; address1 = 144'd500; writeData = 144'd77;
        rst = 1'b0;
        #1;
        check("midrst/buf", bufferOut, '0);
        check("midrst/q", 182'(q), '0);
        check("midrst/gpio2", 182'(gpio2), '0);
        ref_buf = '0; ref_q = '0; ref_gpio2 = '0;
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        idle(); opType = 2'b10; opCode = 4'd1; memToReg = 1'b1; address1 = 144'd500;
        step("midrst_ld");
        check("midrst/mem500", 182'(bufferOut[23:0]), 182'd35);

        for (int n = 0; n < 400; n++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 9))
                0, 1:    ra = 24'hFFFFF0 | 24'($urandom_range(0, 3));
                2:       ra = 24'(1016 + $urandom_range(0, 7));
                3:       ra = 24'($urandom);
                default: ra = 24'(($urandom_range(0, 3) << 10) | $urandom_range(0, 63));
            endcase
            en        = ($urandom_range(0, 7) != 0);
            opType    = $urandom_range(0, 1) ? 2'b10 : 2'($urandom_range(0, 3));
            opCode    = 4'($urandom);
            memWrite  = 1'($urandom);
            memToReg  = 1'($urandom);
            regWrite  = 1'($urandom);
            regWriteV = 1'($urandom);
            modeSel   = 1'($urandom);
            Rc        = 4'($urandom);
            address1  = {rnd[119:0], ra};
            address2  = 24'($urandom);
            writeData = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
            switches  = 4'($urandom);
            gpio1     = {4'($urandom), $urandom};
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
